debounce_count_multi: RTL and testbench

- Multi-channel debounce characterisation block: per channel, counts raw (synchronised) rising edges and debounced press ticks, so switch bounce shows up as raw_cnt > db_cnt.
- Generalises the single-button raw-vs-debounced counter test:
  - N channels, each with its own explicit FSMD debouncer.
  - Input synchroniser on every channel.
  - Parametrised counter width.
  - Wrap or saturate mode.
  - Per-channel clear.
  - Registered channel-select readout that feeds the hex display mux.

---
 rtl/debounce_count_multi_pkg.sv | 20 ++
 rtl/debounce_count_multi_fsmd_ch.sv | 89 ++++++++
 rtl/debounce_count_multi.sv | 105 ++++++++++
 tb/tb_debounce_count_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_count_multi_pkg.sv
// Shared definitions for the multi-channel debounce characterisation block:
// debouncer state encodings, counter mode constants and a width helper.
package debounce_count_multi_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } db_state_e;

    localparam int SAT_MODE_WRAP = 0;
    localparam int SAT_MODE_SAT  = 1;

    // Down-counter width: ceil(log2(cycles)), never less than one bit.
    function automatic int q_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_count_multi_fsmd_ch.sv
// One debounce channel: two-flop synchroniser, edge-detect flop and an
// FSMD that accepts a level change after DB_CYCLES+1 stable samples.
module debounce_fsmd_ch
    import debounce_count_multi_pkg::*;
#(
    parameter int DB_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick,
    output logic raw_tick
);

    localparam int              Q_W    = q_width(DB_CYCLES);
    localparam logic [Q_W-1:0]  Q_LOAD = Q_W'(DB_CYCLES - 1);
    localparam logic [Q_W-1:0]  Q_ONE  = Q_W'(1);

    logic           sync1_q;
    logic           sw_s_q;
    logic           sw_d_q;
    db_state_e      state_q, state_d;
    logic [Q_W-1:0] q_q, q_d;
    logic           tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sw_s_q  <= 1'b0;
            sw_d_q  <= 1'b0;
            state_q <= ST_ZERO;
            q_q     <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sw;
            sw_s_q  <= sync1_q;
            sw_d_q  <= sw_s_q;
            state_q <= state_d;
            q_q     <= q_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (sw_s_q) begin
                    state_d = ST_WAIT1;
                    q_d     = Q_LOAD;
                end
            end
            ST_WAIT1: begin
                if (!sw_s_q) begin
                    state_d = ST_ZERO;
                end else if (q_q == '0) begin
                    state_d = ST_ONE;
                    tick_d  = 1'b1;
                end else begin
                    q_d = q_q - Q_ONE;
                end
            end
            ST_ONE: begin
                if (!sw_s_q) begin
                    state_d = ST_WAIT0;
                    q_d     = Q_LOAD;
                end
            end
            ST_WAIT0: begin
                // A return to high while waiting is a release glitch: no new tick.
                if (sw_s_q) begin
                    state_d = ST_ONE;
                end else if (q_q == '0) begin
                    state_d = ST_ZERO;
                end else begin
                    q_d = q_q - Q_ONE;
                end
            end
        endcase
    end

    assign db_level = (state_q == ST_ONE) || (state_q == ST_WAIT0);
    assign db_tick  = tick_q;
    assign raw_tick = sw_s_q & ~sw_d_q;

endmodule

// File: rtl/debounce_count_multi.sv
// Multi-channel raw-edge vs debounced-press counter with per-channel clear,
// wrap/saturate counters and a registered channel-select readout.
module debounce_count_multi
    import debounce_count_multi_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int SEL_W     = 1,
    parameter int DB_CYCLES = 2000000,
    parameter int CNT_W     = 8,
    parameter int SAT_MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  sw,
    input  logic [N_CH-1:0]  clr,
    input  logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  db_level,
    output logic [N_CH-1:0]  db_tick,
    output logic [CNT_W-1:0] raw_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic [CNT_W-1:0] diff_o
);

    localparam int N_SEL = 1 << SEL_W;

    logic [N_CH-1:0]  raw_tick;
    logic [CNT_W-1:0] raw_pad [N_SEL];
    logic [CNT_W-1:0] db_pad  [N_SEL];
    logic [CNT_W-1:0] raw_cnt_o_q, raw_cnt_o_d;
    logic [CNT_W-1:0] db_cnt_o_q, db_cnt_o_d;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if ((SAT_MODE == SAT_MODE_SAT) && (v == '1)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Unused select codes read as zero-valued channels.
    for (genvar gi = 0; gi < N_SEL; gi++) begin : g_sel
        if (gi < N_CH) begin : g_ch
            logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;
            logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

            debounce_fsmd_ch #(
                .DB_CYCLES (DB_CYCLES)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .sw       (sw[gi]),
                .db_level (db_level[gi]),
                .db_tick  (db_tick[gi]),
                .raw_tick (raw_tick[gi])
            );

            always_comb begin
                raw_cnt_d = raw_cnt_q;
                db_cnt_d  = db_cnt_q;
                if (clr[gi]) begin
                    raw_cnt_d = '0;
                    db_cnt_d  = '0;
                end else begin
                    if (raw_tick[gi]) raw_cnt_d = bump(raw_cnt_q);
                    if (db_tick[gi])  db_cnt_d  = bump(db_cnt_q);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    raw_cnt_q <= '0;
                    db_cnt_q  <= '0;
                end else begin
                    raw_cnt_q <= raw_cnt_d;
                    db_cnt_q  <= db_cnt_d;
                end
            end

            assign raw_pad[gi] = raw_cnt_q;
            assign db_pad[gi]  = db_cnt_q;
        end else begin : g_pad
            assign raw_pad[gi] = '0;
            assign db_pad[gi]  = '0;
        end
    end

    always_comb begin
        raw_cnt_o_d = raw_pad[sel];
        db_cnt_o_d  = db_pad[sel];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            raw_cnt_o_q <= '0;
            db_cnt_o_q  <= '0;
        end else begin
            raw_cnt_o_q <= raw_cnt_o_d;
            db_cnt_o_q  <= db_cnt_o_d;
        end
    end

    assign raw_cnt_o = raw_cnt_o_q;
    assign db_cnt_o  = db_cnt_o_q;
    assign diff_o    = raw_cnt_o_q - db_cnt_o_q;

endmodule

// File: tb/tb_debounce_count_multi.sv
// Bench for debounce_count_multi: table-driven clean press, directed corner
// sequences, and randomized traffic against a run-length reference model.
module tb_debounce_count_multi;

    localparam int N_CH = 4;
    localparam int DB   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] sw_a, clr_a, lvl_a, tick_a;
    logic [1:0] sel_a;
    logic [7:0] raw_a, dbc_a, diff_a;
    logic [2:0] sw_b, clr_b, lvl_b, tick_b;
    logic [1:0] sel_b;
    logic [7:0] raw_b, dbc_b, diff_b;

    debounce_count_multi #(
        .N_CH(4), .SEL_W(2), .DB_CYCLES(DB), .CNT_W(8), .SAT_MODE(0)
    ) dut_a (
        .clk(clk), .reset(reset), .sw(sw_a), .clr(clr_a), .sel(sel_a),
        .db_level(lvl_a), .db_tick(tick_a),
        .raw_cnt_o(raw_a), .db_cnt_o(dbc_a), .diff_o(diff_a)
    );

    // Three-channel saturating build: exercises saturation and unused sel codes.
    debounce_count_multi #(
        .N_CH(3), .SEL_W(2), .DB_CYCLES(DB), .CNT_W(8), .SAT_MODE(1)
    ) dut_b (
        .clk(clk), .reset(reset), .sw(sw_b), .clr(clr_b), .sel(sel_b),
        .db_level(lvl_b), .db_tick(tick_b),
        .raw_cnt_o(raw_b), .db_cnt_o(dbc_b), .diff_o(diff_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: sw history, accepted level plus the length of the current
    // run of samples disagreeing with it; a level flips after DB+1 such samples.
    bit m_h   [N_CH][3];
    bit m_lvl [N_CH];
    int m_run [N_CH];
    bit m_tick[N_CH];
    int m_raw [N_CH];
    int m_db  [N_CH];
    int m_out_raw, m_out_db;

    logic [3:0] lvl_or;
    int         tick_cnt [N_CH];

    typedef struct {
        logic [3:0] sw;
        logic [1:0] sel;
        logic       exp_tick0;
        logic       exp_lvl0;
        logic [7:0] exp_raw;
        logic [7:0] exp_db;
        logic [7:0] exp_diff;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nraw [N_CH];
        int  ndb  [N_CH];
        bit  ntick[N_CH];
        bit  sws, swd;
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                m_h[c][0] = 0; m_h[c][1] = 0; m_h[c][2] = 0;
                m_lvl[c] = 0; m_run[c] = 0; m_tick[c] = 0; m_raw[c] = 0; m_db[c] = 0;
            end
            m_out_raw = 0;
            m_out_db  = 0;
            return;
        end
        m_out_raw = m_raw[sel_a];
        m_out_db  = m_db[sel_a];
        for (int c = 0; c < N_CH; c++) begin
            sws = m_h[c][1];
            swd = m_h[c][2];
            ntick[c] = 0;
            if (clr_a[c]) begin
                nraw[c] = 0;
                ndb[c]  = 0;
            end else begin
                nraw[c] = (sws && !swd) ? (m_raw[c] + 1) % 256 : m_raw[c];
                ndb[c]  = m_tick[c] ? (m_db[c] + 1) % 256 : m_db[c];
            end
            if (sws != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DB + 1) begin
                    m_lvl[c] = sws;
                    m_run[c] = 0;
                    ntick[c] = sws;
                end
            end else begin
                m_run[c] = 0;
            end
            m_h[c][2] = m_h[c][1];
            m_h[c][1] = m_h[c][0];
            m_h[c][0] = sw_a[c];
        end
        for (int c = 0; c < N_CH; c++) begin
            m_raw[c]  = nraw[c];
            m_db[c]   = ndb[c];
            m_tick[c] = ntick[c];
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("model_level%0d", c), lvl_a[c], m_lvl[c]);
            chk($sformatf("model_tick%0d", c), tick_a[c], m_tick[c]);
        end
        chk("model_raw_cnt_o", raw_a, m_out_raw);
        chk("model_db_cnt_o", dbc_a, m_out_db);
        chk("model_diff_o", diff_a, (m_out_raw - m_out_db) & 255);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
        lvl_or |= lvl_a;
        for (int c = 0; c < N_CH; c++) tick_cnt[c] += int'(tick_a[c]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        lvl_or = '0;
        for (int c = 0; c < N_CH; c++) tick_cnt[c] = 0;
    endtask

    initial begin
        reset = 1'b0;
        sw_a = '0; clr_a = '0; sel_a = '0;
        sw_b = '0; clr_b = '0; sel_b = '0;
        clear_obs();

        // Clean press on channel 0, checked after each edge k (sw first high at edge 0).
        tbl[0]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
        tbl[1]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
        tbl[2]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
        tbl[3]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1};
        tbl[4]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1};
        tbl[5]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1};
        tbl[6]  = '{4'b0001, 2'd0, 1'b1, 1'b1, 8'd1, 8'd0, 8'd1};
        tbl[7]  = '{4'b0001, 2'd0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd1};
        tbl[8]  = '{4'b0001, 2'd0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0};
        tbl[9]  = '{4'b0001, 2'd0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0};
        tbl[10] = '{4'b0001, 2'd0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0};
        tbl[11] = '{4'b0001, 2'd0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0};

        steps(2);
        chk("reset_raw_cnt_o", raw_a, 0);
        chk("reset_db_level", lvl_a, 0);
        chk("reset_b_raw_cnt_o", raw_b, 0);
        reset = 1'b1;
        steps(2);

        for (int k = 0; k < 12; k++) begin
            sw_a  = tbl[k].sw;
            sel_a = tbl[k].sel;
            step();
            chk($sformatf("press_tick0[%0d]", k), tick_a[0], tbl[k].exp_tick0);
            chk($sformatf("press_level0[%0d]", k), lvl_a[0], tbl[k].exp_lvl0);
            chk($sformatf("press_raw[%0d]", k), raw_a, tbl[k].exp_raw);
            chk($sformatf("press_db[%0d]", k), dbc_a, tbl[k].exp_db);
            chk($sformatf("press_diff[%0d]", k), diff_a, tbl[k].exp_diff);
        end
        steps(8);
        sw_a = '0;
        steps(10);

        // Bounce on channel 1: two raw edges, never accepted.
        sel_a = 2'd1;
        clear_obs();
        sw_a[1] = 1'b1; steps(2);
        sw_a[1] = 1'b0; steps(2);
        sw_a[1] = 1'b1; steps(2);
        sw_a[1] = 1'b0; steps(10);
        chk("bounce_raw", raw_a, 2);
        chk("bounce_db", dbc_a, 0);
        chk("bounce_diff", diff_a, 2);
        chk("bounce_level_seen", lvl_or[1], 0);
        sel_a = 2'd0;
        step();
        chk("sel_switch_raw", raw_a, 1);
        chk("sel_switch_db", dbc_a, 1);

        // Release glitch on channel 2: ONE -> WAIT0 -> ONE without a second tick.
        sel_a = 2'd2;
        clear_obs();
        sw_a[2] = 1'b1; steps(10);
        for (int i = 0; i < 14; i++) begin
            sw_a[2] = (i >= 2);
            step();
            chk($sformatf("glitch_level[%0d]", i), lvl_a[2], 1);
        end
        chk("glitch_ticks", tick_cnt[2], 1);
        chk("glitch_db", dbc_a, 1);
        sw_a[2] = 1'b0; steps(10);

        // 256 clean presses: wrap on dut_a channel 3, saturate on dut_b channel 2.
        sel_a = 2'd3;
        sel_b = 2'd2;
        for (int p = 0; p < 256; p++) begin
            sw_a[3] = 1'b1; sw_b[2] = 1'b1; steps(8);
            sw_a[3] = 1'b0; sw_b[2] = 1'b0; steps(8);
        end
        chk("wrap_raw", raw_a, 0);
        chk("wrap_db", dbc_a, 0);
        chk("sat_raw", raw_b, 255);
        chk("sat_db", dbc_b, 255);
        chk("sat_diff", diff_b, 0);
        sel_b = 2'd3;
        step();
        chk("oob_raw", raw_b, 0);
        chk("oob_db", dbc_b, 0);
        chk("oob_diff", diff_b, 0);
        sel_b = 2'd2;
        step();
        chk("oob_back_raw", raw_b, 255);

        // Clear on the same edge as a raw increment; the later db tick still counts.
        sw_a[3] = 1'b1; steps(8);
        sw_a[3] = 1'b0; steps(8);
        chk("pre_clr_raw", raw_a, 1);
        sw_a[3] = 1'b1; steps(2);
        clr_a[3] = 1'b1; step();
        clr_a[3] = 1'b0; steps(6);
        sw_a[3] = 1'b0; steps(8);
        chk("clr_raw", raw_a, 0);
        chk("clr_db", dbc_a, 1);
        chk("clr_diff", diff_a, 255);

        // Reset while channel 0 is in WAIT1 with q=2.
        sel_a = 2'd0;
        clear_obs();
        sw_a[0] = 1'b1; steps(4);
        reset = 1'b0; step();
        chk("midreset_tick", tick_a, 0);
        chk("midreset_level", lvl_a, 0);
        chk("midreset_raw", raw_a, 0);
        chk("midreset_db", dbc_a, 0);
        chk("midreset_diff", diff_a, 0);
        chk("midreset_b_db", dbc_b, 0);
        chk("midreset_ticks", tick_cnt[0], 0);
        reset = 1'b1;
        steps(12);
        chk("restart_ticks", tick_cnt[0], 1);
        chk("restart_level", lvl_a[0], 1);
        chk("restart_db", dbc_a, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 5) == 0) sw_a[c] = ~sw_a[c];
                clr_a[c] = ($urandom_range(0, 63) == 0);
            end
            sel_a = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
